uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync_vote.sv | 46 ++++
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity mode constants
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_vote.sv
// rtl/uart_rx_sync_vote.sv - rx line synchroniser and mid-bit 2-of-3 majority vote
module uart_rx_sync_vote #(
  parameter int OVERSAMPLE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_wire,
  input  logic                          baud_tick,
  input  logic [$clog2(OVERSAMPLE)-1:0] tick_cnt,
  output logic                          rx_sync,
  output logic                          vote,
  output logic                          vote_tick
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_P1 = CW'(OVERSAMPLE / 2 + 1);

  logic       meta;
  logic [1:0] samp;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx_wire;
      rx_sync <= meta;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= 2'b11;
    end else if (baud_tick && (tick_cnt == MID_M1 || tick_cnt == MID)) begin
      samp <= {samp[0], rx_sync};
    end
  end

  assign vote      = (samp[1] & samp[0]) | (samp[1] & rx_sync) | (samp[0] & rx_sync);
  assign vote_tick = baud_tick && (tick_cnt == MID_P1);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver with parity/stop checking and FIFO write strobe
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_wire,
  input  logic                 data_in_full,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 data_in_write,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_next;
  logic [CW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_bad;
  logic                 par_bad;
  logic                 rx_sync;
  logic                 vote;
  logic                 vote_tick;
  logic                 bit_end;
  logic                 last_stop_vote;
  logic                 stop_low;
  logic                 par_sum;
  logic                 wr_next;
  logic                 ferr_next;
  logic                 perr_next;
  logic                 ovr_next;

  uart_rx_sync_vote #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sync_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_wire  (rx_wire),
    .baud_tick(baud_tick),
    .tick_cnt (tick_cnt),
    .rx_sync  (rx_sync),
    .vote     (vote),
    .vote_tick(vote_tick)
  );

  assign bit_end        = baud_tick && (tick_cnt == TICK_LAST);
  assign last_stop_vote = (state == ST_STOP) && vote_tick && (bit_cnt == STOP_LAST);
  // Any earlier stop bit that voted low also counts as a framing error
  assign stop_low       = stop_bad || !vote;
  assign par_sum        = (^shreg) ^ vote;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decisions; every transition lands on a baud_tick
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (baud_tick && !rx_sync) state_next = ST_START;
      ST_START:     if (vote_tick && vote) state_next = ST_IDLE;
                    else if (bit_end) state_next = ST_DATA;
      ST_DATA:      if (bit_end && bit_cnt == DATA_LAST)
                      state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_end) state_next = ST_STOP;
      ST_STOP:      if (last_stop_vote) state_next = stop_low ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (baud_tick && rx_sync) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Frame outcome at the last stop-bit vote, highest priority first
  always_comb begin
    wr_next   = 1'b0;
    ferr_next = 1'b0;
    perr_next = 1'b0;
    ovr_next  = 1'b0;
    if (last_stop_vote) begin
      if (stop_low) ferr_next = 1'b1;
      else if (par_bad) perr_next = 1'b1;
      else if (data_in_full) ovr_next = 1'b1;
      else wr_next = 1'b1;
    end
  end

  // Tick counter restarts at the start-bit detect; bit counter restarts per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_tick) begin
      if (state == ST_IDLE || state == ST_WAIT_HIGH) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (bit_end) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift voted data bits and latch parity/stop verdicts as they are voted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      stop_bad <= 1'b0;
      par_bad  <= 1'b0;
    end else if (vote_tick) begin
      case (state)
        ST_START: begin
          stop_bad <= 1'b0;
          par_bad  <= 1'b0;
        end
        ST_DATA: begin
          if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], vote};
          else shreg <= {vote, shreg[DATA_BITS-1:1]};
        end
        ST_PARITY: par_bad <= (PARITY == PARITY_ODD) ? !par_sum : par_sum;
        ST_STOP:   if (!vote) stop_bad <= 1'b1;
        default:   ;
      endcase
    end
  end

  // Registered one-cycle pulses; data_in only moves on an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in       <= '0;
      data_in_write <= 1'b0;
      frame_err     <= 1'b0;
      parity_err    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      data_in_write <= wr_next;
      frame_err     <= ferr_next;
      parity_err    <= perr_next;
      overrun       <= ovr_next;
      if (wr_next) data_in <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int OS      = 8;
  localparam int DB      = 8;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;
  localparam int EV_OVR  = 3;
  localparam int EV_WR   = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          baud_tick = 1'b0;
  logic          rx_a, rx_b, full_a, full_b;
  logic [DB-1:0] data_a, data_b;
  logic          wr_a, fe_a, pe_a, ov_a;
  logic          wr_b, fe_b, pe_b, ov_b;

  int n_cmp = 0;
  int n_bad = 0;
  int q_a[$];
  int q_b[$];
  int last_data[2];
  int sel;
  int unsigned tick_gap = 0;

  uart_rx_core u_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_wire(rx_a),
    .data_in_full(full_a), .data_in(data_a), .data_in_write(wr_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_core #(.PARITY(PARITY_EVEN)) u_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_wire(rx_b),
    .data_in_full(full_b), .data_in(data_b), .data_in_write(wr_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;

  // One-clock baud ticks with a random 3..5 clock spacing
  always @(posedge clk) begin
    if (tick_gap == 0) begin
      baud_tick <= 1'b1;
      tick_gap  <= $urandom_range(4, 2);
    end else begin
      baud_tick <= 1'b0;
      tick_gap  <= tick_gap - 1;
    end
  end

  // Record every output pulse as an event, away from the active edge
  always @(negedge clk) begin
    if (wr_a) q_a.push_back(EV_WR + int'(data_a));
    if (fe_a) q_a.push_back(EV_FERR);
    if (pe_a) q_a.push_back(EV_PERR);
    if (ov_a) q_a.push_back(EV_OVR);
    if (wr_b) q_b.push_back(EV_WR + int'(data_b));
    if (fe_b) q_b.push_back(EV_FERR);
    if (pe_b) q_b.push_back(EV_PERR);
    if (ov_b) q_b.push_back(EV_OVR);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    #1;
  endtask

  task automatic drive(input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_bit(input logic v);
    drive(v);
    repeat (OS) wait_tick();
  endtask

  task automatic idle(input int n);
    drive(1'b1);
    repeat (n) wait_tick();
  endtask

  // Reference outcome of one frame, straight from the decision priority
  function automatic int frame_outcome(input bit bad_stop, input bit bad_par,
                                       input bit full, input logic [DB-1:0] d);
    if (bad_stop) return EV_FERR;
    if (bad_par) return EV_PERR;
    if (full) return EV_OVR;
    return EV_WR + int'(d);
  endfunction

  task automatic check_frame(input int dut, input int exp_ev);
    int n;
    int ev;
    if (dut == 0) begin
      n  = q_a.size();
      ev = (n > 0) ? q_a[0] : -1;
      q_a.delete();
    end else begin
      n  = q_b.size();
      ev = (n > 0) ? q_b[0] : -1;
      q_b.delete();
    end
    check(dut == 0 ? "a_pulse_count" : "b_pulse_count", n, 1);
    check(dut == 0 ? "a_event" : "b_event", ev, exp_ev);
    if (exp_ev >= EV_WR) last_data[dut] = exp_ev - EV_WR;
    check(dut == 0 ? "a_data_in" : "b_data_in",
          dut == 0 ? int'(data_a) : int'(data_b), last_data[dut]);
  endtask

  // Serialise one frame LSB first; dut 1 carries an even parity bit
  task automatic send_frame(input int dut, input logic [DB-1:0] d, input bit flip_par,
                            input bit bad_stop, input bit full, input int hold_low);
    sel = dut;
    if (dut == 0) full_a = full;
    else full_b = full;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (dut == 1) send_bit((^d) ^ flip_par);
    send_bit(!bad_stop);
    repeat (hold_low) send_bit(1'b0);
    drive(1'b1);
    check_frame(dut, frame_outcome(bad_stop, (dut == 1) && flip_par, full, d));
  endtask

  initial begin
    logic [DB-1:0] d;
    int            dut;
    bit            flip, bad, full;

    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    full_a = 1'b0;
    full_b = 1'b0;
    sel = 0;
    last_data[0] = 0;
    last_data[1] = 0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_in", int'(data_a), 0);
    check("rst_pulses", int'({wr_a, fe_a, pe_a, ov_a, wr_b, fe_b, pe_b, ov_b}), 0);
    check("rst_state", int'(u_a.state), int'(ST_IDLE));
    rst_n = 1'b1;
    idle(4);

    // back-to-back frames
    send_frame(0, 8'hAA, 0, 0, 0, 0);
    send_frame(0, 8'h55, 0, 0, 0, 0);
    idle(3);

    // false start: low for three ticks only
    sel = 0;
    drive(1'b0);
    repeat (3) wait_tick();
    idle(10);
    check("false_start_pulses", q_a.size(), 0);
    check("false_start_state", int'(u_a.state), int'(ST_IDLE));
    send_frame(0, 8'h3C, 0, 0, 0, 0);
    idle(2);

    // parity: wrong then right parity bit for 0x07
    send_frame(1, 8'h07, 1, 0, 0, 0);
    send_frame(1, 8'h07, 0, 0, 0, 0);
    idle(2);

    // stop low then line held low for 20 bit times
    send_frame(0, 8'h00, 0, 1, 0, 20);
    check("wait_high_state", int'(u_a.state), int'(ST_WAIT_HIGH));
    idle(OS);
    send_frame(0, 8'h81, 0, 0, 0, 0);
    idle(2);

    // overrun keeps the previous word
    send_frame(0, 8'h5A, 0, 0, 1, 0);
    send_frame(0, 8'hA5, 0, 0, 0, 0);
    idle(2);

    // reset in the middle of the data bits of 0xFF
    sel = 0;
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_data_in", int'(data_a), 0);
    check("midreset_pulses", int'({wr_a, fe_a, pe_a, ov_a}), 0);
    check("midreset_state", int'(u_a.state), int'(ST_IDLE));
    last_data[0] = 0;
    last_data[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_tick();
    idle(2 * OS);
    check("midreset_no_pulse", q_a.size(), 0);
    send_frame(0, 8'h12, 0, 0, 0, 0);
    idle(2);

    // randomized frames against the reference outcome
    for (int k = 0; k < 40; k++) begin
      dut  = int'($urandom_range(1, 0));
      d    = DB'($urandom);
      flip = (dut == 1) && ($urandom_range(3, 0) == 0);
      bad  = ($urandom_range(7, 0) == 0);
      full = ($urandom_range(4, 0) == 0);
      send_frame(dut, d, flip, bad, full, 0);
      idle(bad ? int'($urandom_range(3, 1)) : int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
